// File: rtl/mul_approx_pkg.sv
// Shared types and helpers for the sequential approximate multiplier.
// col_mask gives, for partial-product row j, which multiplicand bits survive truncation at K.
package mul_approx_pkg;

  // Widest operand that col_mask can describe.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // trunc_k width: holds every K from 0 (exact) to 2W (drop everything).
  function automatic int unsigned kw_of(input int unsigned w);
    return $clog2(2 * w + 1);
  endfunction

  // Bit i of the mask is set when column i+j >= k, so that bit of row j is kept.
  function automatic logic [MAX_W-1:0] col_mask(input int unsigned j, input int unsigned k);
    if (k <= j) return '1;
    // A shift of MAX_W or more yields 0, so the mask correctly collapses to all-zero.
    return ~((MAX_W'(1) << (k - j)) - MAX_W'(1));
  endfunction

endpackage

// File: rtl/mul_approx_row.sv
// One partial-product row of the broken-array multiplier: A gated by B[j], shifted to
// column j, with columns below K removed; flags whether any removed bit was a one.
module mul_approx_row
  import mul_approx_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned KW = kw_of(W),
  parameter int unsigned CW = $clog2(W)
) (
  input  logic [W-1:0]   a,
  input  logic [CW-1:0]  j,
  input  logic [KW-1:0]  k,
  input  logic           b_j,
  output logic [2*W-1:0] row,
  output logic           dropped
);

  localparam int unsigned PW = 2 * W;

  logic [W-1:0] keep;
  logic [W-1:0] sel;

  assign keep    = W'(col_mask(32'(j), 32'(k)));
  assign sel     = a & {W{b_j}};
  assign row     = PW'(sel & keep) << j;
  assign dropped = |(sel & ~keep);

endmodule

// File: rtl/mul_approx_seq.sv
// Sequential shift-add approximate unsigned multiplier, one row of B per cycle,
// with runtime column truncation and valid/ready handshakes on both sides.
module mul_approx_seq
  import mul_approx_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned KW = kw_of(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [KW-1:0]  trunc_k,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] O,
  output logic           inexact
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W);

  state_e          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [KW-1:0]   k_q;
  logic [PW-1:0]   acc;
  logic            drop;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   row;
  logic            row_drop;
  logic            accept;
  logic            last_row;

  // DONE forwards the consumer's ready so a new operand pair can enter on the pop edge.
  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_row  = (cnt == CW'(W - 1));

  mul_approx_row #(
    .W  (W),
    .KW (KW),
    .CW (CW)
  ) u_row (
    .a       (a_q),
    .j       (cnt),
    .k       (k_q),
    .b_j     (b_q[cnt]),
    .row     (row),
    .dropped (row_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      acc     <= '0;
      drop    <= 1'b0;
      cnt     <= '0;
      O       <= '0;
      inexact <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) state <= BUSY;
        end
        BUSY: begin
          acc  <= acc + row;
          drop <= drop | row_drop;
          cnt  <= cnt + CW'(1);
          if (last_row) begin
            state   <= DONE;
            O       <= acc + row;
            inexact <= drop | row_drop;
          end
        end
        DONE: begin
          if (out_ready) state <= in_valid ? BUSY : IDLE;
        end
        default: state <= IDLE;
      endcase

      // Operand capture is shared by the IDLE and back-to-back DONE paths.
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        k_q  <= trunc_k;
        acc  <= '0;
        drop <= 1'b0;
        cnt  <= '0;
      end
    end
  end

endmodule
